// File: rtl/hit_readout_pkg.sv
// Shared constants, FSM state codes and frame-length helper for the hit readout transmitter.
// Define HIT_READOUT_TIMESTAMP_EN to add a 4-byte cycle timestamp to every frame.
package hit_readout_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         TS_BYTES  = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COINC   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  // Header + hit bytes + optional timestamp + checksum.
  function automatic int frame_len(input int n_ch);
`ifdef HIT_READOUT_TIMESTAMP_EN
    return 2 + n_ch / 8 + TS_BYTES;
`else
    return 2 + n_ch / 8;
`endif
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first. ready rises during the final stop-bit cycle so a start
// issued then chains the next start bit with no idle gap (CLKS_PER_BIT must be >= 2).
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_reg;
  logic [3:0]    bit_reg;
  logic [8:0]    shift_reg;
  logic          busy_reg;
  logic          tx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '1;
      busy_reg  <= 1'b0;
      tx_reg    <= 1'b1;
    end else if (!busy_reg) begin
      if (start) begin
        busy_reg  <= 1'b1;
        tx_reg    <= 1'b0;
        shift_reg <= {1'b1, data};
        cnt_reg   <= '0;
        bit_reg   <= '0;
      end
    end else if (bit_reg == 4'd9 && cnt_reg == CW'(CLKS_PER_BIT - 2)) begin
      // Last stop-bit cycle is spent in the ready state, where tx already idles high.
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
      cnt_reg   <= '0;
      bit_reg   <= bit_reg + 4'd1;
      tx_reg    <= shift_reg[0];
      shift_reg <= {1'b1, shift_reg[8:1]};
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign ready = !busy_reg;
  assign tx    = tx_reg;

endmodule

// File: rtl/hit_readout_tx.sv
// Hit readout: coincidence wait, snapshot + latch clear, then one framed UART packet per event.
// Optional HIT_READOUT_TIMESTAMP_EN inserts a 32-bit cycle timestamp (MSB first) after the hits.
module hit_readout_tx
  import hit_readout_pkg::*;
#(
  parameter int N_CH           = 8,
  parameter int CLKS_PER_BIT   = 868,
  parameter int COINC_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] hits,
  output logic            clr_latch,
  output logic            tx,
  output logic            busy,
  output logic [15:0]     frame_cnt
);

  localparam int HIT_BYTES = N_CH / 8;
  localparam int FRAME_LEN = frame_len(N_CH);
`ifdef HIT_READOUT_TIMESTAMP_EN
  localparam int PAY_BYTES = HIT_BYTES + TS_BYTES;
`else
  localparam int PAY_BYTES = HIT_BYTES;
`endif

  logic [2:0]      state_reg;
  logic [15:0]     coinc_reg;
  logic [31:0]     hold_reg;
  logic [N_CH-1:0] snap_reg;
  logic [15:0]     idx_reg;
  logic [7:0]      csum_reg;
  logic [15:0]     frame_cnt_reg;
  logic [7:0]      payload [PAY_BYTES];
  logic [7:0]      pay_byte;
  logic [7:0]      tx_byte;
  logic            uart_ready;
  logic            send_start;

  genvar gi;
  generate
    for (gi = 0; gi < HIT_BYTES; gi++) begin : g_hit_bytes
      assign payload[gi] = snap_reg[gi*8 +: 8];
    end
  endgenerate

`ifdef HIT_READOUT_TIMESTAMP_EN
  logic [31:0] ts_cnt_reg;
  logic [31:0] ts_snap_reg;

  generate
    for (gi = 0; gi < TS_BYTES; gi++) begin : g_ts_bytes
      assign payload[HIT_BYTES + gi] = ts_snap_reg[31 - gi*8 -: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_reg  <= '0;
      ts_snap_reg <= '0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + 32'd1;
      if (state_reg == ST_IDLE && |hits)
        ts_snap_reg <= ts_cnt_reg;
    end
  end
`endif

  // idx 0 is the header, 1..PAY_BYTES the payload, FRAME_LEN-1 the checksum.
  always_comb begin
    pay_byte = '0;
    for (int i = 0; i < PAY_BYTES; i++)
      if (idx_reg == 16'(i + 1))
        pay_byte = payload[i];
    if (idx_reg == 16'd0)
      tx_byte = FRAME_HDR;
    else if (idx_reg == 16'(FRAME_LEN - 1))
      tx_byte = csum_reg;
    else
      tx_byte = pay_byte;
  end

  assign send_start = (state_reg == ST_SEND) && uart_ready && (idx_reg != 16'(FRAME_LEN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      coinc_reg     <= '0;
      hold_reg      <= '0;
      snap_reg      <= '0;
      idx_reg       <= '0;
      csum_reg      <= '0;
      frame_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|hits) begin
            state_reg <= ST_COINC;
            coinc_reg <= '0;
          end
        end
        ST_COINC: begin
          if (coinc_reg == 16'(COINC_CYCLES - 1))
            state_reg <= ST_CAPTURE;
          else
            coinc_reg <= coinc_reg + 16'd1;
        end
        ST_CAPTURE: begin
          snap_reg  <= hits;
          idx_reg   <= '0;
          csum_reg  <= '0;
          state_reg <= ST_SEND;
        end
        ST_SEND: begin
          if (uart_ready) begin
            if (idx_reg == 16'(FRAME_LEN)) begin
              // ready here means the final stop bit is on the line this cycle.
              frame_cnt_reg <= frame_cnt_reg + 16'd1;
              hold_reg      <= '0;
              state_reg     <= (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
            end else begin
              idx_reg <= idx_reg + 16'd1;
              if (idx_reg != 16'd0)
                csum_reg <= csum_reg ^ tx_byte;
            end
          end
        end
        ST_HOLDOFF: begin
          if (hold_reg == 32'(HOLDOFF_CYCLES - 1))
            state_reg <= ST_IDLE;
          else
            hold_reg <= hold_reg + 32'd1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(send_start),
    .data (tx_byte),
    .ready(uart_ready),
    .tx   (tx)
  );

  assign clr_latch = (state_reg == ST_CAPTURE);
  assign busy      = (state_reg != ST_IDLE);
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_hit_readout_tx.sv
// Randomised bench for hit_readout_tx: a cycle-indexed event timeline model plus a UART
// line decoder; both derive expectations from frame layout and timing rules only.
module tb_hit_readout_tx;

  localparam int N_CH  = 16;
  localparam int CPB   = 8;
  localparam int COINC = 5;
  localparam int HOLD  = 12;
`ifdef HIT_READOUT_TIMESTAMP_EN
  localparam int FLEN = 2 + N_CH / 8 + 4;
`else
  localparam int FLEN = 2 + N_CH / 8;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] hits = '0;
  logic            clr_latch;
  logic            tx;
  logic            busy;
  logic [15:0]     frame_cnt;

  always #5 clk = ~clk;

  hit_readout_tx #(
    .N_CH(N_CH), .CLKS_PER_BIT(CPB), .COINC_CYCLES(COINC), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .hits(hits), .clr_latch(clr_latch),
    .tx(tx), .busy(busy), .frame_cnt(frame_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event model: one event in flight, all times expressed as negedge/cycle indices.
  int          k = 0;
  bit          m_act = 1'b0;
  int          k0 = 0, cap = 0, fc_at = 0, idle_at = 0;
  logic [15:0] m_cnt = '0;
  logic [31:0] ts_m = '0;
  logic [31:0] m_ts = '0;
  bit          rst_prev = 1'b1;
  bit          clr_seen = 1'b0;
  logic [7:0]  exp_q [$];
  logic [7:0]  dec_q [$];
  int          dec_st = 0, dec_cnt = 0, dec_bit = 0, first_start = -1;
  logic [7:0]  dec_byte = '0;

  task automatic build_frame();
    logic [7:0] cs;
    logic [7:0] v;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int b = 0; b < N_CH / 8; b++) begin
      v = hits[b*8 +: 8];
      exp_q.push_back(v);
      cs = cs ^ v;
    end
`ifdef HIT_READOUT_TIMESTAMP_EN
    for (int t = 3; t >= 0; t--) begin
      v = m_ts[t*8 +: 8];
      exp_q.push_back(v);
      cs = cs ^ v;
    end
`endif
    exp_q.push_back(cs);
  endtask

  task automatic compare_frame();
    logic [31:0] got;
    check("frame_len", 32'(dec_q.size()), 32'(FLEN));
    for (int i = 0; i < FLEN; i++) begin
      got = (i < dec_q.size()) ? 32'(dec_q[i]) : 32'hFFFF_FFFF;
      check($sformatf("frame_byte%0d", i), got, 32'(exp_q[i]));
    end
    check("first_start_cycle", 32'(first_start), 32'(cap + 2));
    $display("frame %0d: %0d bytes, hdr %0h, cs %0h", m_cnt, dec_q.size(), exp_q[0], exp_q[FLEN-1]);
    dec_q.delete();
    first_start = -1;
  endtask

  task automatic step(input logic [N_CH-1:0] set_bits, input bit ext_clr, input bit do_rst);
    bit clr_now;
    @(negedge clk);
    k++;
    if (rst_prev) ts_m = '0; else ts_m = ts_m + 32'd1;
    if (m_act && k == fc_at) begin
      m_cnt = m_cnt + 16'd1;
      compare_frame();
    end
    if (m_act && k == idle_at) m_act = 1'b0;

    check("busy", 32'(busy), 32'(m_act && k > k0));
    check("clr_latch", 32'(clr_latch), 32'(m_act && k == cap));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    if (!(m_act && k >= cap + 2 && k < fc_at))
      check("tx_idle", 32'(tx), 32'd1);

    case (dec_st)
      0: if (tx === 1'b0) begin
           if (dec_q.size() == 0) first_start = k;
           dec_cnt = CPB / 2;
           dec_st = 1;
         end
      1: begin
           dec_cnt--;
           if (dec_cnt == 0) begin
             check("start_bit", 32'(tx), 32'd0);
             dec_cnt = CPB; dec_bit = 0; dec_byte = '0; dec_st = 2;
           end
         end
      2: begin
           dec_cnt--;
           if (dec_cnt == 0) begin
             dec_byte[dec_bit] = tx;
             dec_bit++;
             dec_cnt = CPB;
             if (dec_bit == 8) dec_st = 3;
           end
         end
      default: begin
           dec_cnt--;
           if (dec_cnt == 0) begin
             check("stop_bit", 32'(tx), 32'd1);
             dec_q.push_back(dec_byte);
             dec_st = 0;
           end
         end
    endcase

    // Latch bank: a clear pulse seen this cycle takes effect at the next edge.
    clr_now = clr_latch;
    if (clr_seen || ext_clr) hits = '0;
    hits = hits | set_bits;
    clr_seen = clr_now;
    rst = do_rst;

    if (do_rst) begin
      m_act = 1'b0;
      m_cnt = '0;
      dec_q.delete();
      dec_st = 0;
      first_start = -1;
      clr_seen = 1'b0;
    end else if (!m_act && hits != '0) begin
      m_act   = 1'b1;
      k0      = k;
      cap     = k + COINC + 1;
      fc_at   = cap + 2 + FLEN * 10 * CPB;
      idle_at = fc_at + HOLD;
      m_ts    = ts_m;
    end
    if (m_act && k == cap) build_frame();
    rst_prev = do_rst;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      step('0, 1'b0, 1'b0);
      n++;
    end while (m_act && n < 20000);
    check("event_done", 32'(m_act), 32'd0);
  endtask

  initial begin
    logic [N_CH-1:0] set;
    repeat (3) step('0, 1'b0, 1'b1);
    repeat (10000) step('0, 1'b0, 1'b0);

    // Abort mid-payload, then a clean frame.
    step(16'h0005, 1'b0, 1'b0);
    repeat (COINC + 2 + 13 * CPB) step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    repeat (20) step('0, 1'b0, 1'b0);
    step(16'h0005, 1'b0, 1'b0);
    wait_idle();

    // Late hit inside the coincidence window joins the snapshot.
    step(16'h0081, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(16'h0002, 1'b0, 1'b0);
    wait_idle();

    // External clear during COINC still yields a frame with zero hits.
    step(16'h0040, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    wait_idle();

    // Hit arriving during SEND is served after the holdoff.
    step(16'h1234, 1'b0, 1'b0);
    repeat (100) step('0, 1'b0, 1'b0);
    step(16'h8000, 1'b0, 1'b0);
    wait_idle();

    for (int i = 0; i < 15000; i++) begin
      set = '0;
      if ($urandom_range(0, 149) == 0) set = N_CH'($urandom());
      step(set, 1'b0, $urandom_range(0, 3999) == 0);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
